// File: rtl/cr_iu_reg_rd_port_pkg.sv
// Shared types and constants for the IU register read port (cr_iu_rd_pkg).
// Optional parity output is enabled with CR_IU_RD_PARITY_EN.
package cr_iu_rd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } rd_state_e;

  localparam int DEF_REG_NUM = 16;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_DATA_W  = 32;

  // LSB of register idx inside the flattened bank output bus.
  function automatic int slice_lsb(input int idx, input int data_w);
    return idx * data_w;
  endfunction

endpackage

// File: rtl/cr_iu_reg_rd_port_if.sv
// Read request / read beat handshake between IU consumers and the read port.
// The rd_par signal exists only when CR_IU_RD_PARITY_EN is defined.
interface cr_iu_reg_rd_port_if #(
  parameter int IDX_W  = cr_iu_rd_pkg::DEF_IDX_W,
  parameter int DATA_W = cr_iu_rd_pkg::DEF_DATA_W
) ();
  logic              rd_req;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_ack;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              rd_rdy;
  logic              rd_busy;
`ifdef CR_IU_RD_PARITY_EN
  logic              rd_par;

  modport master (output rd_req, rd_idx, rd_rdy,
                  input  rd_ack, rd_vld, rd_data, rd_err, rd_busy, rd_par);
  modport slave  (input  rd_req, rd_idx, rd_rdy,
                  output rd_ack, rd_vld, rd_data, rd_err, rd_busy, rd_par);
`else
  modport master (output rd_req, rd_idx, rd_rdy,
                  input  rd_ack, rd_vld, rd_data, rd_err, rd_busy);
  modport slave  (input  rd_req, rd_idx, rd_rdy,
                  output rd_ack, rd_vld, rd_data, rd_err, rd_busy);
`endif
endinterface

// File: rtl/cr_iu_reg_rd_port_sel.sv
// Combinational index decode and read-after-write bypass mux for the read port.
// Independent of CR_IU_RD_PARITY_EN.
module cr_iu_reg_rd_sel
  import cr_iu_rd_pkg::*;
#(
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic [REG_NUM*DATA_W-1:0] reg_dout_bus,
  input  logic                      write_en,
  input  logic [IDX_W-1:0]          write_idx,
  input  logic [DATA_W-1:0]         write_data,
  output logic [DATA_W-1:0]         sel_data,
  output logic                      sel_err
);
  localparam logic [31:0] REG_NUM_U = 32'(REG_NUM);

  logic [DATA_W-1:0] bank [REG_NUM];
  logic [DATA_W-1:0] bank_sel;
  logic              in_range;
  logic              bypass;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_slice
      assign bank[gi] = reg_dout_bus[slice_lsb(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  always_comb begin
    bank_sel = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd_idx == IDX_W'(i)) bank_sel = bank[i];
    end
  end

  // The bank commits write_data on the same edge we capture, so a matching
  // write must win over the (still old) bank output.
  always_comb begin
    in_range = (32'(rd_idx) < REG_NUM_U);
    bypass   = write_en && (write_idx == rd_idx) && in_range;
    sel_err  = !in_range;
    if (!in_range)   sel_data = '0;
    else if (bypass) sel_data = write_data;
    else             sel_data = bank_sel;
  end

endmodule

// File: rtl/cr_iu_reg_rd_port.sv
// One-entry registered read port over the IU register bank with write bypass.
// Define CR_IU_RD_PARITY_EN to add the registered even-parity output rd_par.
module cr_iu_reg_rd_port
  import cr_iu_rd_pkg::*;
#(
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  cr_iu_reg_rd_port_if.slave        rd,
  input  logic [REG_NUM*DATA_W-1:0] x_reg_dout_bus,
  input  logic                      x_write_en,
  input  logic [IDX_W-1:0]          x_write_idx,
  input  logic [DATA_W-1:0]         write_data
);
  rd_state_e         state_reg;
  rd_state_e         state_next;
  logic              vld;
  logic              ack;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_err;
  logic [DATA_W-1:0] data_reg;
  logic              err_reg;

  cr_iu_reg_rd_sel #(
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) u_sel (
    .rd_idx       (rd.rd_idx),
    .reg_dout_bus (x_reg_dout_bus),
    .write_en     (x_write_en),
    .write_idx    (x_write_idx),
    .write_data   (write_data),
    .sel_data     (sel_data),
    .sel_err      (sel_err)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = VALID;
      VALID:   if (rd.rd_rdy) state_next = accept ? VALID : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Consuming and accepting in the same cycle keeps the pipe bubble-free.
  always_comb begin
    vld    = (state_reg == VALID);
    ack    = !vld || rd.rd_rdy;
    accept = rd.rd_req && ack;
  end

  assign rd.rd_vld  = vld;
  assign rd.rd_ack  = ack;
  assign rd.rd_busy = vld && !rd.rd_rdy;
  assign rd.rd_data = data_reg;
  assign rd.rd_err  = err_reg;

  // Snapshot at accept only; later writes to the held index do not leak in.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      data_reg <= '0;
      err_reg  <= 1'b0;
    end else if (accept) begin
      data_reg <= sel_data;
      err_reg  <= sel_err;
    end
  end

`ifdef CR_IU_RD_PARITY_EN
  logic par_reg;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)   par_reg <= 1'b0;
    else if (accept) par_reg <= ^sel_data;
  end

  assign rd.rd_par = par_reg;
`endif

endmodule

// File: tb/tb_cr_iu_reg_rd_port.sv
// Bench for cr_iu_reg_rd_port (REG_NUM=12): vector table, corner sequences, random vs. model.
// Parity checks are compiled in when CR_IU_RD_PARITY_EN is defined.
module tb_cr_iu_reg_rd_port;
  localparam int REG_NUM = 12;
  localparam int IDX_W   = 4;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic [REG_NUM*DATA_W-1:0] bus;
  logic                      wen;
  logic [IDX_W-1:0]          widx;
  logic [DATA_W-1:0]         wdata;
  logic [DATA_W-1:0]         bank [REG_NUM];

  int n_chk;
  int n_fail;

  cr_iu_reg_rd_port_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) rd_if ();

  cr_iu_reg_rd_port #(.REG_NUM(REG_NUM), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .rd             (rd_if),
    .x_reg_dout_bus (bus),
    .x_write_en     (wen),
    .x_write_idx    (widx),
    .write_data     (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The register bank lives in the bench and feeds the DUT's bus input.
  always @(posedge clk) begin
    if (wen && 32'(widx) < REG_NUM) bank[widx] <= wdata;
  end

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) bus[i*DATA_W +: DATA_W] = bank[i];
  end

  typedef struct {
    logic [IDX_W-1:0]  pre_idx;
    logic [DATA_W-1:0] pre_val;
    logic [IDX_W-1:0]  idx;
    logic              w_en;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
  } beat_t;

  vec_t  vecs [8];
  beat_t q [$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rd_if.rd_req = 1'b0;
    rd_if.rd_idx = '0;
    rd_if.rd_rdy = 1'b1;
    wen          = 1'b0;
    widx         = '0;
    wdata        = '0;
  endtask

  task automatic bank_write(input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] v);
    wen = 1'b1; widx = i; wdata = v;
    tick();
    wen = 1'b0;
  endtask

  task automatic read_one(input string name, input logic [IDX_W-1:0] i,
                          input logic [DATA_W-1:0] exp_d, input logic exp_e);
    rd_if.rd_req = 1'b1; rd_if.rd_idx = i; rd_if.rd_rdy = 1'b1;
    tick();
    rd_if.rd_req = 1'b0;
    @(negedge clk);
    chk({name, "_vld"}, 32'(rd_if.rd_vld), 32'd1);
    chk({name, "_data"}, rd_if.rd_data, exp_d);
    chk({name, "_err"}, 32'(rd_if.rd_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < REG_NUM; i++) bank[i] = '0;
    //            pre_idx pre_val        idx   w_en  w_idx  w_data         exp_data       exp_err
    vecs[0] = '{4'd3,  32'hDEADBEEF, 4'd3,  1'b0, 4'd0,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1] = '{4'd5,  32'h00000000, 4'd5,  1'b1, 4'd5,  32'h12345678, 32'h12345678, 1'b0};
    vecs[2] = '{4'd2,  32'h00000000, 4'd14, 1'b0, 4'd0,  32'h0,        32'h00000000, 1'b1};
    vecs[3] = '{4'd11, 32'hCAFEF00D, 4'd11, 1'b0, 4'd0,  32'h0,        32'hCAFEF00D, 1'b0};
    vecs[4] = '{4'd0,  32'h11111111, 4'd12, 1'b1, 4'd12, 32'hAAAAAAAA, 32'h00000000, 1'b1};
    vecs[5] = '{4'd7,  32'h77777777, 4'd7,  1'b1, 4'd6,  32'h66666666, 32'h77777777, 1'b0};
    vecs[6] = '{4'd0,  32'h00000000, 4'd0,  1'b1, 4'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{4'd1,  32'h01010101, 4'd15, 1'b0, 4'd0,  32'h0,        32'h00000000, 1'b1};

    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(rd_if.rd_vld), 32'd0);
    chk("rst_data", rd_if.rd_data, 32'd0);
    chk("rst_err", 32'(rd_if.rd_err), 32'd0);
    chk("rst_busy", 32'(rd_if.rd_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single reads from idle, each consumed immediately.
    for (int v = 0; v < 8; v++) begin
      bank_write(vecs[v].pre_idx, vecs[v].pre_val);
      rd_if.rd_req = 1'b1; rd_if.rd_idx = vecs[v].idx; rd_if.rd_rdy = 1'b1;
      wen = vecs[v].w_en; widx = vecs[v].w_idx; wdata = vecs[v].w_data;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", v), 32'(rd_if.rd_ack), 32'd1);
      tick();
      rd_if.rd_req = 1'b0; wen = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_vld", v), 32'(rd_if.rd_vld), 32'd1);
      chk($sformatf("vec%0d_data", v), rd_if.rd_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_err", v), 32'(rd_if.rd_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_busy", v), 32'(rd_if.rd_busy), 32'd0);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_idle", v), 32'(rd_if.rd_vld), 32'd0);
      $display("vec %0d: idx=%0d data=%h err=%0d", v, vecs[v].idx, rd_if.rd_data, rd_if.rd_err);
      tick();
    end

    // Back-pressure: held snapshot, ignored requests, then consume+accept.
    bank_write(4'd2, 32'h22220000);
    bank_write(4'd7, 32'h70707070);
    rd_if.rd_req = 1'b1; rd_if.rd_idx = 4'd2; rd_if.rd_rdy = 1'b1;
    tick();
    rd_if.rd_rdy = 1'b0; rd_if.rd_idx = 4'd9;
    wen = 1'b1; widx = 4'd2; wdata = 32'h2BAD2BAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_vld", c), 32'(rd_if.rd_vld), 32'd1);
      chk($sformatf("bp%0d_ack", c), 32'(rd_if.rd_ack), 32'd0);
      chk($sformatf("bp%0d_busy", c), 32'(rd_if.rd_busy), 32'd1);
      chk($sformatf("bp%0d_data", c), rd_if.rd_data, 32'h22220000);
      tick();
      wen = 1'b0;
    end
    rd_if.rd_rdy = 1'b1; rd_if.rd_idx = 4'd7;
    @(negedge clk);
    chk("bp_release_ack", 32'(rd_if.rd_ack), 32'd1);
    chk("bp_release_busy", 32'(rd_if.rd_busy), 32'd0);
    tick();
    rd_if.rd_req = 1'b0;
    @(negedge clk);
    chk("bp_next_vld", 32'(rd_if.rd_vld), 32'd1);
    chk("bp_next_data", rd_if.rd_data, 32'h70707070);
    $display("backpressure: second beat data=%h", rd_if.rd_data);
    tick();
    @(negedge clk);
    chk("bp_drain", 32'(rd_if.rd_vld), 32'd0);
    tick();

    // Asynchronous reset while a beat is stalled.
    rd_if.rd_req = 1'b1; rd_if.rd_idx = 4'd3; rd_if.rd_rdy = 1'b0;
    tick();
    rd_if.rd_req = 1'b0;
    @(negedge clk);
    chk("arst_pre_vld", 32'(rd_if.rd_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(rd_if.rd_vld), 32'd0);
    chk("arst_data", rd_if.rd_data, 32'd0);
    chk("arst_busy", 32'(rd_if.rd_busy), 32'd0);
    tick();
    rst_n = 1'b1; rd_if.rd_rdy = 1'b1;
    @(negedge clk);
    chk("arst_post_ack", 32'(rd_if.rd_ack), 32'd1);
    chk("arst_post_data", rd_if.rd_data, 32'd0);
    tick();
    @(negedge clk);
    chk("arst_no_replay", 32'(rd_if.rd_vld), 32'd0);
    $display("async reset: beat dropped");
    tick();

`ifdef CR_IU_RD_PARITY_EN
    bank_write(4'd1, 32'h00000007);
    bank_write(4'd4, 32'h00000003);
    rd_if.rd_req = 1'b1; rd_if.rd_idx = 4'd1;
    tick();
    rd_if.rd_idx = 4'd4;
    @(negedge clk);
    chk("par_7", 32'(rd_if.rd_par), 32'd1);
    tick();
    rd_if.rd_req = 1'b0;
    @(negedge clk);
    chk("par_3", 32'(rd_if.rd_par), 32'd0);
    tick();
    read_one("par_seq", 4'd1, 32'h00000007, 1'b0);
`else
    read_one("plain_seq", 4'd3, 32'hDEADBEEF, 1'b0);
`endif

    // Random traffic against a one-deep queue model of the port.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic  exp_ack;
      beat_t b;
      rd_if.rd_req = ($urandom_range(0, 3) != 0);
      rd_if.rd_idx = IDX_W'($urandom_range(0, 15));
      rd_if.rd_rdy = ($urandom_range(0, 2) != 0);
      wen          = $urandom_range(0, 1) == 1;
      widx         = ($urandom_range(0, 2) == 0) ? rd_if.rd_idx : IDX_W'($urandom_range(0, 15));
      wdata        = $urandom;
      @(negedge clk);
      exp_ack = (q.size() == 0) || rd_if.rd_rdy;
      chk("rnd_ack", 32'(rd_if.rd_ack), 32'(exp_ack));
      chk("rnd_vld", 32'(rd_if.rd_vld), 32'(q.size() != 0));
      chk("rnd_busy", 32'(rd_if.rd_busy), 32'((q.size() != 0) && !rd_if.rd_rdy));
      if (q.size() != 0) begin
        chk("rnd_data", rd_if.rd_data, q[0].d);
        chk("rnd_err", 32'(rd_if.rd_err), 32'(q[0].e));
`ifdef CR_IU_RD_PARITY_EN
        chk("rnd_par", 32'(rd_if.rd_par), 32'(^q[0].d));
`endif
        if (rd_if.rd_rdy)
          $display("rnd %0d: beat data=%h err=%0d", c, q[0].d, q[0].e);
      end
      if ((q.size() != 0) && rd_if.rd_rdy) void'(q.pop_front());
      if (rd_if.rd_req && exp_ack) begin
        b.e = (32'(rd_if.rd_idx) >= REG_NUM);
        if (b.e)                                 b.d = '0;
        else if (wen && widx == rd_if.rd_idx)    b.d = wdata;
        else                                     b.d = bank[rd_if.rd_idx];
        q.push_back(b);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
